// File: rtl/fifo_pkg.sv
// fifo_pkg: shared types for the systolic-array FIFOs (collector state encoding)
package fifo_pkg;
  typedef enum logic {COLLECT, FULL} state_t;
endpackage

// File: rtl/fifo_collect.sv
// fifo_collect: serial-to-parallel drain collector assembling DIM elements into a handshaked vector
// Ports: clk/rst_n (async active-low), en/din/in_ready element input, clr sync abort,
//        q/out_valid/RdEn vector output handshake, count elements held, ovf sticky overflow.
module fifo_collect
  import fifo_pkg::*;
#(
  parameter int DIM = 8,
  parameter int BITS = 64,
  localparam int CW = $clog2(DIM + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [BITS-1:0]           din,
  output logic                      in_ready,
  input  logic                      clr,
  output logic [DIM-1:0][BITS-1:0]  q,
  output logic                      out_valid,
  input  logic                      RdEn,
  output logic [CW-1:0]             count,
  output logic                      ovf
);
  state_t                     state_q;
  logic [DIM-1:0][BITS-1:0]   vec_q;
  logic [CW-1:0]              cnt_q;
  logic                       ovf_q;
  logic                       accept;
  logic                       consume;
  assign out_valid = state_q == FULL;
  assign in_ready  = !out_valid || RdEn;
  assign accept    = en && in_ready;
  assign consume   = out_valid && RdEn;
  assign q         = vec_q;
  assign count     = cnt_q;
  assign ovf       = ovf_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      vec_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else if (clr) begin
      state_q <= COLLECT;
      vec_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (en && !in_ready) ovf_q <= 1'b1;
      if (consume) begin
        // reading the full vector frees the collector, so a same-cycle element starts the next one
        state_q  <= COLLECT;
        vec_q    <= '0;
        vec_q[0] <= accept ? din : '0;
        cnt_q    <= CW'(accept);
      end else if (accept) begin
        for (int i = 0; i < DIM; i++)
          if (cnt_q == CW'(i)) vec_q[i] <= din;
        cnt_q <= cnt_q + CW'(1);
        if (cnt_q == CW'(DIM - 1)) state_q <= FULL;
      end
    end
  end
endmodule
